// File: rtl/uart_rx_io.sv
// 8N1 UART receiver feeding a first-word-fall-through FIFO with sticky error flags.
// Define UART_RX_PARITY_EN to expect one even-parity bit between the data and stop bits.
module uart_rx_io #(
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUD_RATE   = 1000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       i_uart_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  input  logic       i_ready,
  input  logic       i_clr,
  output logic       o_overrun,
  output logic       o_frame_err,
  output logic       o_parity_err,
  output logic       o_busy
);

  localparam int DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  generate
    if (DIV < 4) begin : g_div_chk
      $error("uart_rx_io: CLK_FREQ_HZ/BAUD_RATE must be >= 4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_chk
      $error("uart_rx_io: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  logic          rx_meta_q, rx_sync_q, rx_prev_q, rx_fall;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          cnt_zero, push, frame_set;
`ifdef UART_RX_PARITY_EN
  logic          par_bad_q, par_bad_d, parity_set, parity_q;
`endif

  // Flops preset to idle-high so reset never fakes a start edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign rx_fall  = rx_prev_q & ~rx_sync_q;
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shreg_q   <= '0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shreg_q   <= shreg_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    push       = 1'b0;
    frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d  = par_bad_q;
    parity_set = 1'b0;
`endif
    if (state_q != S_IDLE && !cnt_zero) cnt_d = cnt_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          cnt_d   = CNT_HALF;
          state_d = S_START;
        end
      end
      S_START: begin
        if (cnt_zero) begin
          if (!rx_sync_q) begin
            cnt_d   = CNT_FULL;
            idx_d   = '0;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt_zero) begin
          shreg_d = {rx_sync_q, shreg_q[7:1]};
          idx_d   = idx_q + 1'b1;
          cnt_d   = CNT_FULL;
          if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (cnt_zero) begin
          par_bad_d = rx_sync_q ^ (^shreg_q);
          cnt_d     = CNT_FULL;
          state_d   = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (cnt_zero) begin
          if (rx_sync_q) begin
            state_d = S_IDLE;
`ifdef UART_RX_PARITY_EN
            parity_set = par_bad_q;
            push       = ~par_bad_q;
`else
            push = 1'b1;
`endif
          end else begin
            frame_set = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_set = par_bad_q;
`endif
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_sync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (state_q != S_IDLE);
  end

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   fcnt_q;
  logic          full, pop, do_push, overrun_set;
  logic          overrun_q, frame_q;

  assign full        = (fcnt_q == DEPTH_C);
  assign o_valid     = (fcnt_q != '0);
  assign pop         = o_valid & i_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign do_push     = push & (~full | pop);
  assign overrun_set = push & full & ~pop;
  assign o_data      = o_valid ? mem_q[rd_q] : 8'h00;

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= shreg_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (pop)     rd_q <= rd_q + 1'b1;
      case ({do_push, pop})
        2'b10:   fcnt_q <= fcnt_q + 1'b1;
        2'b01:   fcnt_q <= fcnt_q - 1'b1;
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  // New errors win over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
      frame_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      overrun_q <= overrun_set | (overrun_q & ~i_clr);
      frame_q   <= frame_set | (frame_q & ~i_clr);
`ifdef UART_RX_PARITY_EN
      parity_q  <= parity_set | (parity_q & ~i_clr);
`endif
    end
  end

  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_q;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = parity_q;
`else
  assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_io.sv
// Randomized bench for uart_rx_io; expected bytes/flags come from a queue model of an 8N1 link.
`timescale 1ns/1ps
module tb_uart_rx_io;
  localparam int BIT = 100;
  localparam int FDEPTH = 4;

  logic       clk = 1'b0, resetn = 1'b0, rx = 1'b1, i_ready = 1'b0, i_clr = 1'b0;
  logic [7:0] o_data;
  logic       o_valid, o_overrun, o_frame_err, o_parity_err, o_busy;

  uart_rx_io dut (
    .clk(clk), .resetn(resetn), .i_uart_rx(rx),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready), .i_clr(i_clr),
    .o_overrun(o_overrun), .o_frame_err(o_frame_err), .o_parity_err(o_parity_err),
    .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int   t_fall = 0, t_valid = -1;
  logic v_prev = 1'b0;
  always @(negedge clk) begin
    if (o_valid && !v_prev && t_valid < 0) t_valid = cyc;
    v_prev = o_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; the line is left at the stop-bit level for the caller.
  task automatic send(input logic [7:0] b, input logic par, input logic stop);
    t_fall = cyc;
    rx = 1'b0; tick(BIT);
    for (int i = 0; i < 8; i++) begin rx = b[i]; tick(BIT); end
`ifdef UART_RX_PARITY_EN
    rx = par; tick(BIT);
`else
    if (par === 1'bx) $display("parity bit unknown");
`endif
    rx = stop; tick(BIT);
  endtask

  task automatic clr_pulse();
    i_clr = 1'b1; tick(1); i_clr = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic ovr, input logic frm, input logic par);
    chk({tag, "_ovr"}, 32'(o_overrun), 32'(ovr));
    chk({tag, "_frm"}, 32'(o_frame_err), 32'(frm));
    chk({tag, "_par"}, 32'(o_parity_err), 32'(par));
  endtask

  logic [7:0] exp_q[$];
  logic [7:0] b;
  logic [7:0] c3 = 8'hC3;
  logic [7:0] tx5 [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data",  32'(o_data),  32'd0);
    chk("rst_busy",  32'(o_busy),  32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    resetn = 1'b1; tick(5);

    // Single byte: latency from line fall to o_valid
    t_valid = -1;
    send(8'h55, ^8'h55, 1'b1); rx = 1'b1; tick(2);
    chk("t1_seen", 32'(t_valid >= 0), 32'd1);
    chk("t1_lat_window", 32'((t_valid - t_fall) >= 950 && (t_valid - t_fall) <= 956), 32'd1);
    chk("t1_valid", 32'(o_valid), 32'd1);
    chk("t1_data",  32'(o_data),  32'h55);
    chk("t1_busy",  32'(o_busy),  32'd0);
    chk_flags("t1", 1'b0, 1'b0, 1'b0);
    i_ready = 1'b1; tick(1); i_ready = 1'b0;
    chk("t1_popped", 32'(o_valid), 32'd0);

    // Short glitch must be rejected as a false start
    rx = 1'b0; tick(20); rx = 1'b1; tick(5);
    chk("glitch_busy", 32'(o_busy), 32'd1);
    tick(30);
    chk("glitch_idle", 32'(o_busy), 32'd0);
    tick(200);
    chk("glitch_novalid", 32'(o_valid), 32'd0);

    // Five back-to-back bytes into a 4-deep FIFO
    for (int i = 0; i < 5; i++) send(tx5[i], ^tx5[i], 1'b1);
    rx = 1'b1; tick(5);
    chk("ovr_flag", 32'(o_overrun), 32'd1);
    i_ready = 1'b1;
    for (int i = 0; i < FDEPTH; i++) begin
      chk("ovr_valid", 32'(o_valid), 32'd1);
      chk("ovr_data",  32'(o_data),  32'(tx5[i]));
      tick(1);
    end
    chk("ovr_drained", 32'(o_valid), 32'd0);
    i_ready = 1'b0;
    clr_pulse();
    chk("ovr_clr", 32'(o_overrun), 32'd0);

    // Framing error followed by a break
    send(8'hA5, ^8'hA5, 1'b0);
    tick(3 * BIT);
    chk("frm_flag",  32'(o_frame_err), 32'd1);
    chk("frm_valid", 32'(o_valid), 32'd0);
    chk("frm_busy",  32'(o_busy), 32'd1);
    rx = 1'b1; tick(5);
    chk("frm_idle",  32'(o_busy), 32'd0);
    chk("frm_sticky", 32'(o_frame_err), 32'd1);
    clr_pulse();
    chk("frm_clr", 32'(o_frame_err), 32'd0);

    // Reset mid-frame (transmitter aborts too), then a clean byte
    rx = 1'b0; tick(BIT);
    for (int i = 0; i < 4; i++) begin rx = c3[i]; tick(BIT); end
    rx = c3[4]; tick(50);
    chk("rst_mid_busy", 32'(o_busy), 32'd1);
    resetn = 1'b0; rx = 1'b1; tick(1); resetn = 1'b1;
    tick(300);
    chk("rst_mid_idle",  32'(o_busy),  32'd0);
    chk("rst_mid_empty", 32'(o_valid), 32'd0);
    send(8'h3C, ^8'h3C, 1'b1); rx = 1'b1; tick(5);
    chk("rst_3c_valid", 32'(o_valid), 32'd1);
    chk("rst_3c_data",  32'(o_data),  32'h3C);
    chk_flags("rst_3c", 1'b0, 1'b0, 1'b0);
    i_ready = 1'b1; tick(1); i_ready = 1'b0;
    chk("rst_3c_only", 32'(o_valid), 32'd0);

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b1); rx = 1'b1; tick(5);
    chk("par_flag",  32'(o_parity_err), 32'd1);
    chk("par_drop",  32'(o_valid), 32'd0);
    send(8'h07, 1'b1, 1'b1); rx = 1'b1; tick(5);
    chk("par_ok_valid", 32'(o_valid), 32'd1);
    chk("par_ok_data",  32'(o_data),  32'h07);
    i_ready = 1'b1; tick(1); i_ready = 1'b0;
    clr_pulse();
    chk("par_clr", 32'(o_parity_err), 32'd0);
`endif

    // Random batches against a bounded-queue model
    for (int bt = 0; bt < 4; bt++) begin
      int  n;
      logic ovr;
      n = $urandom_range(1, 6);
      ovr = 1'b0;
      exp_q.delete();
      for (int k = 0; k < n; k++) begin
        b = 8'($urandom);
        send(b, ^b, 1'b1); rx = 1'b1;
        if (exp_q.size() < FDEPTH) exp_q.push_back(b);
        else ovr = 1'b1;
        tick($urandom_range(1, 30));
      end
      tick(5);
      chk("rnd_ovr",   32'(o_overrun), 32'(ovr));
      chk("rnd_frm",   32'(o_frame_err), 32'd0);
      chk("rnd_busy",  32'(o_busy), 32'd0);
      i_ready = 1'b1;
      while (exp_q.size() > 0) begin
        chk("rnd_valid", 32'(o_valid), 32'd1);
        chk("rnd_data",  32'(o_data),  32'(exp_q.pop_front()));
        tick(1);
      end
      chk("rnd_empty", 32'(o_valid), 32'd0);
      i_ready = 1'b0;
      clr_pulse();
      chk("rnd_clr", 32'(o_overrun), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
